// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that merges NUM_REQ write requesters onto one FIFO
//   write port. Grants are combinational (one-hot req_ready). The winning
//   data is registered onto fifo_data_in with fifo_wr_en one cycle later.
//   A three-state FSM (RUN / BLOCKED / ERROR) throttles grants on FIFO
//   back-pressure and latches FIFO overflow until software clears it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid[N]      per-requester write request
//   req_data[N*W]     per-requester data, slice i = [i*W +: W]
//   req_ready[N]      one-hot grant (transfer = valid & ready)
//   fifo_wr_en        registered FIFO write strobe
//   fifo_data_in[W]   registered FIFO write data (holds when not writing)
//   fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow   FIFO status
//   err_clear         leave ERROR
//   grant_id          index of the last granted requester
//   state_o[2]        FSM state (0 RUN, 1 BLOCKED, 2 ERROR)
//   ack_count[16]     wrapping count of fifo_wr_ack cycles
//   drop_count[16]    wrapping count of fifo_overflow cycles
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_wr_ack,
  input  logic                            fifo_overflow,
  input  logic                            err_clear,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [1:0]                      state_o,
  output logic [15:0]                     ack_count,
  output logic [15:0]                     drop_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BLOCKED = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_grant_id;
  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic [15:0]           r_ack_cnt;
  logic [15:0]           r_drop_cnt;

  logic                  w_throttle;
  logic                  w_grant_en;
  logic [PTR_W-1:0]      w_winner;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  logic [FIFO_WIDTH-1:0] w_win_data;
  logic [PTR_W-1:0]      w_next_ptr;

  // First valid requester at or above ptr, wrapping modulo NUM_REQ.
  // The sum is kept one bit wider so the wrap works for non-power-of-2 N.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] idx;
    logic           done;
    rr_pick = '0;
    done    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!done && v[idx[PTR_W-1:0]]) begin
        rr_pick = idx[PTR_W-1:0];
        done    = 1'b1;
      end
    end
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(1);
    if (s >= (PTR_W+1)'(NUM_REQ)) s = '0;
    ptr_inc = s[PTR_W-1:0];
  endfunction

  // Stage p0: combinational arbitration
  // Almost-full only throttles while a write is already in flight, since
  // that write will consume the last free slot.
  assign w_throttle = fifo_full || (fifo_almostfull && r_wr_en);
  assign w_grant_en = !rst && (r_state == ST_RUN) && !w_throttle;
  assign w_winner   = rr_pick(req_valid, r_rr_ptr);
  assign w_xfer     = w_grant_en && (|req_valid);
  assign w_win_data = req_data[w_winner*FIFO_WIDTH +: FIFO_WIDTH];
  assign w_next_ptr = ptr_inc(w_winner);

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_winner] = 1'b1;
  end

  // Stage p1: registered write port, FSM and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
      r_ack_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_data     <= w_win_data;
        r_rr_ptr   <= w_next_ptr;
        r_grant_id <= w_winner;
      end
      if (fifo_wr_ack)   r_ack_cnt  <= r_ack_cnt + 16'd1;
      if (fifo_overflow) r_drop_cnt <= r_drop_cnt + 16'd1;

      // Overflow wins over throttle and over err_clear.
      if (fifo_overflow) begin
        r_state <= ST_ERROR;
      end else begin
        case (r_state)
          ST_RUN:     if (w_throttle)  r_state <= ST_BLOCKED;
          ST_BLOCKED: if (!w_throttle) r_state <= ST_RUN;
          ST_ERROR:   if (err_clear)   r_state <= ST_RUN;
          default:                     r_state <= ST_RUN;
        endcase
      end
    end
  end

  assign req_ready    = w_ready;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant_id;
  assign state_o      = r_state;
  assign ack_count    = r_ack_cnt;
  assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (FIFO_WIDTH=16, NUM_REQ=4).
// A transaction-level reference model predicts grants, state and counters
// each cycle; expected FIFO writes go into a queue that an independent
// monitor drains whenever the DUT strobes fifo_wr_en.
module tb_fifo_wr_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic           err_clear;
  logic [1:0]     grant_id;
  logic [1:0]     state_o;
  logic [15:0]    ack_count, drop_count;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .err_clear(err_clear), .grant_id(grant_id), .state_o(state_o),
    .ack_count(ack_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_BLK = 1, M_ERR = 2;
  int         m_state = M_RUN;
  int         m_ptr   = 0;
  int         m_gid   = 0;
  bit         m_wren  = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_ack   = 0;
  int         m_drop  = 0;

  logic [W-1:0] exp_q[$];
  int           grant_log[$];

  // Per-cycle: compare DUT against model, queue the expected write, then
  // advance the model at the clock edge.
  task automatic cycle();
    bit           thr, xfer;
    int           win;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    thr  = fifo_full || (fifo_almostfull && m_wren);
    win  = -1;
    if (!rst && m_state == M_RUN && !thr)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    xfer      = (win >= 0);
    exp_ready = '0;
    if (xfer) exp_ready[win] = 1'b1;

    chk("req_ready",  32'(req_ready),  32'(exp_ready));
    chk("state",      32'(state_o),    32'(m_state));
    chk("grant_id",   32'(grant_id),   32'(m_gid));
    chk("ack_count",  32'(ack_count),  32'(m_ack));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("wr_en",      32'(fifo_wr_en), 32'(m_wren));
    chk("data_hold",  32'(fifo_data_in), 32'(m_data));

    for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    if (xfer) exp_q.push_back(req_data[win*W +: W]);

    @(posedge clk);
    if (rst) begin
      m_state = M_RUN; m_ptr = 0; m_gid = 0; m_wren = 1'b0;
      m_data = '0; m_ack = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      m_wren = xfer;
      if (xfer) begin
        m_data = req_data[win*W +: W];
        m_ptr  = (win + 1) % N;
        m_gid  = win;
      end
      if (fifo_wr_ack)   m_ack  = (m_ack + 1) % 65536;
      if (fifo_overflow) m_drop = (m_drop + 1) % 65536;
      if (fifo_overflow)                    m_state = M_ERR;
      else if (m_state == M_RUN && thr)     m_state = M_BLK;
      else if (m_state == M_BLK && !thr)    m_state = M_RUN;
      else if (m_state == M_ERR && err_clear) m_state = M_RUN;
    end
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(fifo_data_in), 32'hDEAD_0000);
      else chk("fifo_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; req_valid = '0; fifo_full = 1'b0; fifo_almostfull = 1'b0;
    fifo_wr_ack = 1'b0; fifo_overflow = 1'b0; err_clear = 1'b0;
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    int seq_exp[8];
    seq_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    idle_inputs();
    rst = 1'b1;
    new_data();
    cycle();
    cycle();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    rst = 1'b0;
    cycle();

    // Fairness: all four valid for eight cycles.
    grant_log.delete();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin new_data(); cycle(); end
    req_valid = '0;
    cycle();
    chk("fair_len", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("fair_order", 32'(grant_log[i]), 32'(seq_exp[i]));

    // Sparse: grant 2 twice (second time with rr_ptr already 3).
    req_valid = 4'b0100; new_data(); cycle();
    req_valid = 4'b0100; new_data(); cycle();
    chk("sparse_grant_id", 32'(grant_id), 32'd2);
    req_valid = '0; cycle();

    // Single requester streaming: full throughput.
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin new_data(); cycle(); end

    // Throttle: almostfull while a write is in flight.
    fifo_almostfull = 1'b1; new_data(); cycle();
    chk("blocked_state", 32'(state_o), 32'd1);
    for (int c = 0; c < 3; c++) begin new_data(); cycle(); end
    fifo_full = 1'b1; cycle(); cycle();
    fifo_full = 1'b0; fifo_almostfull = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin new_data(); cycle(); end

    // Overflow pulse, five blocked cycles, clear.
    fifo_overflow = 1'b1; new_data(); cycle();
    fifo_overflow = 1'b0;
    chk("err_state", 32'(state_o), 32'd2);
    chk("drop_one", 32'(drop_count), 32'd1);
    for (int c = 0; c < 5; c++) begin new_data(); cycle(); end
    err_clear = 1'b1; fifo_overflow = 1'b1; cycle();
    chk("err_hold_with_ovf", 32'(state_o), 32'd2);
    fifo_overflow = 1'b0; cycle();
    err_clear = 1'b0;
    for (int c = 0; c < 4; c++) begin new_data(); cycle(); end

    // Reset in the cycle after a transfer.
    fifo_wr_ack = 1'b1; req_valid = 4'b1000; new_data(); cycle();
    rst = 1'b1; req_valid = 4'hF; cycle();
    rst = 1'b0;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ack", 32'(ack_count), 32'd0);
    fifo_wr_ack = 1'b0; new_data(); cycle();
    chk("rst_first_grant", 32'(grant_id), 32'd0);
    req_valid = '0; cycle();

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      req_valid       = N'($urandom);
      new_data();
      fifo_full       = ($urandom_range(0, 9) == 0);
      fifo_almostfull = ($urandom_range(0, 3) == 0);
      fifo_wr_ack     = $urandom_range(0, 1) == 1;
      fifo_overflow   = ($urandom_range(0, 49) == 0);
      err_clear       = ($urandom_range(0, 3) == 0);
      rst             = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();

    // Counter wrap: 65535 acks, then one more.
    rst = 1'b1; cycle(); rst = 1'b0;
    fifo_wr_ack = 1'b1;
    for (int c = 0; c < 65535; c++) cycle();
    chk("ack_preload", 32'(ack_count), 32'hFFFF);
    cycle();
    fifo_wr_ack = 1'b0;
    cycle();
    chk("ack_wrap", 32'(ack_count), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
